wb_drain: RTL and testbench

Write-buffer drain engine: the read-side consumer of a `fifo_sync_bypass` instance holding posted cache write-backs. It pops packed `{address, byteEnable, data}` entries and issues them as single-beat bus writes, using a write/waitRequest handshake. It sits between the cache's write buffer and the system bus master port. It also provides pause, flush-done and idle signalling to the cache controller.

---
 rtl/wb_drain_pkg.sv | 24 ++
 rtl/wb_drain.sv | 103 ++++++++++
 tb/tb_wb_drain.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_drain_pkg.sv
// Shared types and constants for the write-buffer drain engine.
package wb_drain_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wb_drain_state_e;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int WR_COUNT_WIDTH = 16;

    // Entry layout is {addr, be, data} with data in the LSBs.
    localparam int DATA_LSB = 0;

    function automatic int be_lsb(input int data_width);
        return data_width;
    endfunction

    function automatic int addr_lsb(input int data_width);
        return data_width + data_width / 8;
    endfunction

endpackage

// File: rtl/wb_drain.sv
// Drains posted write-backs from the write-buffer FIFO onto the bus as
// single-beat writes, with pause, flush-done and idle signalling.
module wb_drain
    import wb_drain_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int ENTRY_WIDTH = ADDR_WIDTH + BE_WIDTH + DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rest,
    input  logic                   fifo_empty,
    output logic                   fifo_read,
    input  logic [ENTRY_WIDTH-1:0] fifo_readData,
    output logic [ADDR_WIDTH-1:0]  bus_address,
    output logic [BE_WIDTH-1:0]    bus_byteEnable,
    output logic [DATA_WIDTH-1:0]  bus_writeData,
    output logic                   bus_write,
    input  logic                   bus_waitRequest,
    input  logic                   pause,
    input  logic                   flush,
    output logic                   flush_done,
    output logic                   idle,
    output logic [15:0]            wr_count
);

    localparam int BE_LSB   = be_lsb(DATA_WIDTH);
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

    wb_drain_state_e               state_q, state_d;
    logic                          flush_pending_q, flush_pending_d;
    logic                          flush_done_q, flush_done_d;
    logic [WR_COUNT_WIDTH-1:0]     wr_count_q, wr_count_d;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [BE_WIDTH-1:0]           be_q;
    logic [DATA_WIDTH-1:0]         data_q;

    logic pop;
    logic accept;
    logic idle_w;
    logic flush_req;

    // Pop only a non-empty FIFO, never while paused, and only when the bus
    // slot is free or is being freed this cycle; reset gates the strobe.
    assign pop    = rest && !fifo_empty && !pause &&
                    ((state_q == IDLE) || !bus_waitRequest);
    assign accept = (state_q == WRITE) && !bus_waitRequest;
    assign idle_w = (state_q == IDLE) && fifo_empty;

    // Next-state logic: FSM, write counter and flush tracking.
    always_comb begin
        state_d = state_q;
        if (pop) begin
            state_d = WRITE;
        end else if (accept) begin
            state_d = IDLE;
        end
        wr_count_d      = wr_count_q + {{(WR_COUNT_WIDTH-1){1'b0}}, accept};
        // A new request and an older pending one both complete on idle.
        flush_req       = flush_pending_q || flush;
        flush_done_d    = flush_req && idle_w;
        flush_pending_d = flush_req && !idle_w;
    end

    // FSM and control registers.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state_q         <= IDLE;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            wr_count_q      <= '0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
            wr_count_q      <= wr_count_d;
        end
    end

    // Bus datapath registers: load the FIFO head on pop, otherwise hold.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            addr_q <= '0;
            be_q   <= '0;
            data_q <= '0;
        end else if (pop) begin
            addr_q <= fifo_readData[ADDR_LSB +: ADDR_WIDTH];
            be_q   <= fifo_readData[BE_LSB   +: BE_WIDTH];
            data_q <= fifo_readData[DATA_LSB +: DATA_WIDTH];
        end
    end

    assign fifo_read      = pop;
    assign bus_write      = (state_q == WRITE);
    assign bus_address    = addr_q;
    assign bus_byteEnable = be_q;
    assign bus_writeData  = data_q;
    assign idle           = idle_w;
    assign flush_done     = flush_done_q;
    assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_wb_drain.sv
// Self-checking bench for wb_drain: directed table, corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_wb_drain;

    logic        clk = 1'b0;
    logic        rest;
    logic        fifo_empty;
    logic        fifo_read;
    logic [67:0] fifo_readData;
    logic [31:0] bus_address;
    logic [3:0]  bus_byteEnable;
    logic [31:0] bus_writeData;
    logic        bus_write;
    logic        bus_waitRequest;
    logic        pause;
    logic        flush;
    logic        flush_done;
    logic        idle;
    logic [15:0] wr_count;

    wb_drain dut (
        .clk(clk), .rest(rest), .fifo_empty(fifo_empty), .fifo_read(fifo_read),
        .fifo_readData(fifo_readData), .bus_address(bus_address),
        .bus_byteEnable(bus_byteEnable), .bus_writeData(bus_writeData),
        .bus_write(bus_write), .bus_waitRequest(bus_waitRequest), .pause(pause),
        .flush(flush), .flush_done(flush_done), .idle(idle), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // FIFO contents and reference model state
    logic [67:0] q[$];
    logic [67:0] cur;
    bit          has_cur;
    bit          fl_pend;
    bit          exp_fd;
    logic [15:0] model_cnt;
    int          checks, errors;
    int          bw_cnt, rd_cnt, fd_cnt;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
        int          stall;
        int          exp_bw;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive();
        fifo_empty    = (q.size() == 0);
        fifo_readData = (q.size() == 0) ? 68'd0 : q[0];
    endtask

    // Mid-cycle check of every output, then advance the model to the next edge.
    task automatic monitor();
        bit exp_rd, exp_idle;
        if (!rest) begin
            has_cur = 0; model_cnt = '0; fl_pend = 0; exp_fd = 0;
        end
        exp_idle = !has_cur && fifo_empty;
        exp_rd   = rest && !fifo_empty && !pause && (!has_cur || !bus_waitRequest);
        chk("fifo_read", fifo_read, exp_rd);
        chk("read_empty", fifo_read && fifo_empty, 0);
        chk("bus_write", bus_write, has_cur);
        if (has_cur) chk("bus_entry", {bus_address, bus_byteEnable, bus_writeData}, cur);
        chk("idle", idle, exp_idle);
        chk("flush_done", flush_done, exp_fd);
        chk("wr_count", wr_count, model_cnt);
        bw_cnt += bus_write;
        rd_cnt += fifo_read;
        fd_cnt += flush_done;
        if (rest) begin
            if (has_cur && !bus_waitRequest) model_cnt = model_cnt + 16'd1;
            exp_fd  = (fl_pend || flush) && exp_idle;
            fl_pend = (fl_pend || flush) && !exp_idle;
            if (exp_rd) begin
                cur = q[0]; has_cur = 1;
            end else if (has_cur && !bus_waitRequest) begin
                has_cur = 0;
            end
        end
    endtask

    task automatic cyc();
        bit rd;
        @(negedge clk);
        monitor();
        rd = fifo_read && !fifo_empty;
        @(posedge clk);
        if (rd) void'(q.pop_front());
        #1;
        drive();
    endtask

    initial begin
        int bw0, rd0, fd0;
        logic [15:0] cnt0;
        checks = 0; errors = 0; bw_cnt = 0; rd_cnt = 0; fd_cnt = 0;
        has_cur = 0; fl_pend = 0; exp_fd = 0; model_cnt = '0; cur = '0;
        rest = 0; bus_waitRequest = 0; pause = 0; flush = 0;

        tbl[0] = '{32'h0000_2000, 4'h1, 32'h1111_2222, 0, 1};
        tbl[1] = '{32'hFFFF_FFFC, 4'hC, 32'hA5A5_5A5A, 1, 2};
        tbl[2] = '{32'h8000_0004, 4'h6, 32'h0BAD_F00D, 2, 3};
        tbl[3] = '{32'h1234_5678, 4'h0, 32'hFFFF_FFFF, 5, 6};

        // Reset held with an entry visible: no pop, outputs zero
        q.push_back({32'h0000_1000, 4'hF, 32'hDEAD_BEEF});
        drive();
        repeat (3) cyc();
        chk("reset_fields", {bus_address, bus_byteEnable, bus_writeData}, 68'd0);
        chk("reset_q", q.size(), 1);

        // Release: pop on first edge, single write, then idle
        rest = 1;
        repeat (4) cyc();
        chk("single_wr_count", wr_count, 1);
        chk("single_bw", bw_cnt, 1);

        // Table of single writes with varying stall lengths
        for (int i = 0; i < 4; i++) begin
            q.push_back({tbl[i].addr, tbl[i].be, tbl[i].data});
            bus_waitRequest = (tbl[i].stall > 0);
            drive();
            bw0 = bw_cnt; cnt0 = model_cnt;
            cyc();
            for (int k = 0; k < tbl[i].stall; k++) cyc();
            bus_waitRequest = 0;
            repeat (3) cyc();
            chk("tbl_bw", bw_cnt - bw0, tbl[i].exp_bw);
            chk("tbl_wr_count", wr_count, cnt0 + 16'd1);
        end

        // Back-to-back: four entries, no stalls
        for (int i = 0; i < 4; i++) q.push_back({32'h100 + i * 4, 4'hF, 32'hC0DE_0000 + i});
        drive();
        bw0 = bw_cnt; rd0 = rd_cnt; cnt0 = model_cnt;
        repeat (5) cyc();
        chk("b2b_bw", bw_cnt - bw0, 4);
        chk("b2b_rd", rd_cnt - rd0, 4);
        chk("b2b_wr_count", wr_count, cnt0 + 16'd4);

        // Stall three cycles on the second of three writes
        for (int i = 0; i < 3; i++) q.push_back({32'h200 + i * 4, 4'h3, 32'h5700_0000 + i});
        drive();
        bw0 = bw_cnt;
        repeat (2) cyc();
        bus_waitRequest = 1;
        rd0 = rd_cnt;
        repeat (3) cyc();
        chk("stall_no_read", rd_cnt - rd0, 0);
        bus_waitRequest = 0;
        repeat (3) cyc();
        chk("stall_bw", bw_cnt - bw0, 6);

        // Pause with flush: nothing moves until pause drops, then one pulse
        pause = 1;
        q.push_back({32'h300, 4'hF, 32'h1});
        q.push_back({32'h304, 4'hF, 32'h2});
        drive();
        flush = 1;
        fd0 = fd_cnt; rd0 = rd_cnt;
        cyc();
        flush = 0;
        repeat (4) cyc();
        chk("pause_no_done", fd_cnt - fd0, 0);
        chk("pause_no_read", rd_cnt - rd0, 0);
        chk("pause_q", q.size(), 2);
        pause = 0;
        bw0 = bw_cnt;
        repeat (6) cyc();
        chk("pause_rd", rd_cnt - rd0, 2);
        chk("pause_bw", bw_cnt - bw0, 2);
        chk("pause_done", fd_cnt - fd0, 1);

        // Flush while already idle: pulse in the following cycle
        flush = 1;
        cyc();
        flush = 0;
        fd0 = fd_cnt;
        cyc();
        chk("idle_flush_done", fd_cnt - fd0, 1);

        // Reset during a stalled write
        q.push_back({32'h400, 4'hF, 32'h4444_4444});
        bus_waitRequest = 1;
        drive();
        repeat (2) cyc();
        #2 rest = 0;
        #1;
        chk("rst_bus_write", bus_write, 0);
        chk("rst_wr_count", wr_count, 0);
        repeat (2) cyc();
        rest = 1; bus_waitRequest = 0;
        repeat (3) cyc();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            if (q.size() < 6 && ($urandom % 3) == 0)
                q.push_back({$urandom, 4'($urandom), $urandom});
            bus_waitRequest = (($urandom % 4) == 0);
            pause           = (($urandom % 8) == 0);
            flush           = (($urandom % 16) == 0);
            drive();
            cyc();
        end
        bus_waitRequest = 0; pause = 0; flush = 0;
        repeat (20) cyc();
        chk("drain_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
